// File: rtl/serial_frame_receiver_if.sv
// Parallel-side and serial-line signals of the frame receiver.
// The master side is the receiver. The slave side drives the line and consumes the words.
interface serial_frame_receiver_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  serial_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;
    logic                  parity_error;
    logic                  framing_error;
    logic                  overrun;

    modport master (
        input  serial_in, data_ready,
        output data_out, data_valid, parity_error, framing_error, overrun
    );

    modport slave (
        output serial_in, data_ready,
        input  data_out, data_valid, parity_error, framing_error, overrun
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// Serial-to-parallel frame receiver.
// Frame format: start(1), DATA_WIDTH data bits sent MSB-first, even parity, stop(0).
// Good words are presented on a valid/ready register. Bad frames and overruns
// produce one-cycle error pulses.
module serial_frame_receiver #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    serial_frame_receiver_if.master bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         cnt;
    logic                  par_bad;
    logic                  last_bit;
    logic                  accept, frame_ok, load, ovr, fe, pe;

    assign last_bit = (cnt == CW'(DATA_WIDTH - 1));

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // next-state logic: a 1 on an idle line is a start bit
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.serial_in) state_nx = DATA;
            DATA:    if (last_bit)      state_nx = PARITY;
            PARITY:  state_nx = STOP;
            STOP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // frame resolution on the stop-bit edge, in priority order:
    // framing error, then parity error, then load or overrun
    always_comb begin
        accept   = bus.data_valid && bus.data_ready;
        fe       = (state == STOP) && bus.serial_in;
        pe       = (state == STOP) && !bus.serial_in && par_bad;
        frame_ok = (state == STOP) && !bus.serial_in && !par_bad;
        // a word being accepted on this edge frees the register for the new one
        load     = frame_ok && (!bus.data_valid || bus.data_ready);
        ovr      = frame_ok && bus.data_valid && !bus.data_ready;
    end

    // shift register, bit counter and parity check
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            cnt     <= '0;
            par_bad <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.serial_in) begin
                    shreg <= '0;
                    cnt   <= '0;
                end
                DATA: begin
                    shreg <= {shreg[DATA_WIDTH-2:0], bus.serial_in};
                    cnt   <= cnt + CW'(1);
                end
                PARITY:  par_bad <= (^shreg) ^ bus.serial_in;
                default: ;
            endcase
        end
    end

    // output register, handshake and registered error pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.data_out      <= '0;
            bus.data_valid    <= 1'b0;
            bus.parity_error  <= 1'b0;
            bus.framing_error <= 1'b0;
            bus.overrun       <= 1'b0;
        end else begin
            bus.parity_error  <= pe;
            bus.framing_error <= fe;
            bus.overrun       <= ovr;
            if (load) begin
                bus.data_out   <= shreg;
                bus.data_valid <= 1'b1;
            end else if (accept) begin
                bus.data_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver (DATA_WIDTH=4).
// The reference model works on whole frames: each frame's outcome comes from its
// data, parity and stop bit. The model applies it at the stop-bit edge to an
// abstract output register.
module tb_serial_frame_receiver;
    localparam int DW = 4;

    logic clock;
    logic reset_n;

    serial_frame_receiver_if #(.DATA_WIDTH(DW)) bus ();

    serial_frame_receiver #(.DATA_WIDTH(DW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_vec = 0;
    int n_err = 0;

    // expected state of the parallel side
    logic [DW-1:0] e_data;
    logic          e_valid, e_pe, e_fe, e_ov;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("data_valid",    32'(bus.data_valid),    32'(e_valid));
        chk("data_out",      32'(bus.data_out),      32'(e_data));
        chk("parity_error",  32'(bus.parity_error),  32'(e_pe));
        chk("framing_error", 32'(bus.framing_error), 32'(e_fe));
        chk("overrun",       32'(bus.overrun),       32'(e_ov));
    endtask

    task automatic model_clear();
        e_data = '0; e_valid = 1'b0; e_pe = 1'b0; e_fe = 1'b0; e_ov = 1'b0;
    endtask

    // One clock: drive on the falling edge, update the model at the rising edge, check 1 time unit later.
    // stop_edge marks the edge that samples a frame's stop bit, with that frame's outcome.
    task automatic cycle(input logic sin, input logic rdy, input logic stop_edge,
                         input logic [DW-1:0] word, input logic bad_stop, input logic bad_par);
        logic acc, loaded;
        @(negedge clock);
        bus.serial_in  = sin;
        bus.data_ready = rdy;
        @(posedge clock);
        acc    = e_valid && rdy;
        loaded = 1'b0;
        e_pe = 1'b0; e_fe = 1'b0; e_ov = 1'b0;
        if (stop_edge) begin
            if (bad_stop)                e_fe = 1'b1;
            else if (bad_par)            e_pe = 1'b1;
            else if (!e_valid || rdy) begin
                e_data = word; e_valid = 1'b1; loaded = 1'b1;
            end else                     e_ov = 1'b1;
        end
        if (acc && !loaded) e_valid = 1'b0;
        #1;
        check_all();
    endtask

    function automatic logic pick_rdy(input int rmode, input bit is_stop);
        case (rmode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return is_stop;
            default: return 1'($urandom_range(1, 0));
        endcase
    endfunction

    // rmode: 0 never ready, 1 always ready, 2 ready only on stop edge, 3 random
    task automatic send_frame(input logic [DW-1:0] w, input logic flip, input logic stopb,
                              input int rmode, input int gap);
        logic [DW+2:0] bits;
        bits = {1'b1, w, (^w) ^ flip, stopb};
        for (int i = DW + 2; i >= 0; i--)
            cycle(bits[i], pick_rdy(rmode, i == 0), i == 0, w, stopb, flip);
        for (int g = 0; g < gap; g++)
            cycle(1'b0, pick_rdy(rmode, 1'b0), 1'b0, w, 1'b0, 1'b0);
    endtask

    // reset asserted between edges; outputs must clear without a clock
    task automatic async_reset();
        #2;
        reset_n       = 1'b0;
        bus.serial_in = 1'b0;
        model_clear();
        #1;
        check_all();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.serial_in  = 1'b0;
        bus.data_ready = 1'b0;
        model_clear();
        #1;
        check_all();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // idle line: no activity
        for (int i = 0; i < 20; i++)
            cycle(1'b0, 1'($urandom_range(1, 0)), 1'b0, '0, 1'b0, 1'b0);

        // good frame 1010
        send_frame(4'b1010, 1'b0, 1'b0, 1, 3);
        // parity error, then framing error
        send_frame(4'b1110, 1'b1, 1'b0, 1, 2);
        send_frame(4'b0011, 1'b0, 1'b1, 1, 2);

        // backpressure and overrun, then drain
        send_frame(4'b0011, 1'b0, 1'b0, 0, 0);
        send_frame(4'b0101, 1'b0, 1'b0, 0, 2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);

        // accept-and-refill on the stop edge
        send_frame(4'b1001, 1'b0, 1'b0, 0, 1);
        send_frame(4'b0110, 1'b0, 1'b0, 2, 1);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        // pending word wiped by an async reset
        send_frame(4'b0111, 1'b0, 1'b0, 0, 1);
        async_reset();

        // reset mid-frame after two data bits, then a clean frame
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        async_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        send_frame(4'b1100, 1'b0, 1'b0, 1, 2);

        // randomized frames with random gaps, ready and faults
        for (int f = 0; f < 60; f++)
            send_frame(4'($urandom), ($urandom_range(4, 0) == 0), ($urandom_range(5, 0) == 0),
                       3, $urandom_range(2, 0));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
